// File: rtl/conv_pass_sequencer_pkg.sv
// ============================================================================
// conv_seq_pkg : shared state encoding and default widths for the sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

package conv_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_STREAM   = 3'd2,
    ST_PASS_END = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

  localparam int IF_W_DEF    = 18;
  localparam int FILT_W_DEF  = 16;
  localparam int PSUM_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 1024;

endpackage

`default_nettype wire

// File: rtl/conv_pass_sequencer_bounded_counter.sv
// ============================================================================
// bounded_counter : per-pass word counter, flags when the target is reached
// Revision: 1.0
// ============================================================================
`default_nettype none

module bounded_counter
  import conv_seq_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] target,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         reached
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (inc) begin
      count_q <= count_q + W'(1);
    end
  end

  // A zero target is complete from the first cycle.
  assign reached = (count_q >= target);
  assign count   = count_q;

endmodule

`default_nettype wire

// File: rtl/conv_pass_sequencer.sv
// ============================================================================
// conv_pass_sequencer : drives design_top through a multi-pass convolution
// Revision: 1.0
// ============================================================================
`default_nettype none

module conv_pass_sequencer
  import conv_seq_pkg::*;
#(
  parameter int FILT_ADDR_LEN = 4,
  parameter int IF_ADDR_LEN   = 4,
  parameter int IF_W          = IF_W_DEF,
  parameter int FILT_W        = FILT_W_DEF,
  parameter int PSUM_W        = PSUM_W_DEF,
  parameter int CNT_W         = 8,
  parameter int PASS_W        = 4,
  parameter int TIMEOUT       = TIMEOUT_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [FILT_ADDR_LEN-1:0] cfg_filt_len,
  input  logic [IF_ADDR_LEN-1:0]   cfg_stride_len,
  input  logic [1:0]               cfg_mode,
  input  logic [PASS_W-1:0]        cfg_passes,
  input  logic [CNT_W-1:0]         cfg_if_words,
  input  logic [CNT_W-1:0]         cfg_filt_words,
  input  logic [CNT_W-1:0]         cfg_out_words,
  input  logic                     if_s_valid,
  output logic                     if_s_ready,
  input  logic [IF_W-1:0]          if_s_data,
  input  logic                     filt_s_valid,
  output logic                     filt_s_ready,
  input  logic [FILT_W-1:0]        filt_s_data,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [PSUM_W-1:0]        res_data,
  output logic                     start,
  output logic                     IF_wen,
  output logic                     filter_wen,
  output logic                     outbuf_ren,
  output logic                     psum_buf_wen,
  output logic                     just_add_flag,
  output logic [IF_W-1:0]          IF_din,
  output logic [FILT_W-1:0]        filter_din,
  output logic [PSUM_W-1:0]        P_sum_buff_inp,
  output logic [FILT_ADDR_LEN-1:0] filt_len,
  output logic [IF_ADDR_LEN-1:0]   stride_len,
  output logic [1:0]               calc_mod,
  input  logic                     IF_full,
  input  logic                     filter_full,
  input  logic                     outbuf_empty,
  input  logic                     psum_full,
  input  logic [PSUM_W-1:0]        outbuf_dout,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  state_e                   state_q, state_d;
  logic [PASS_W-1:0]        pass_cnt_q, pass_cnt_d, last_idx_q;
  logic [CNT_W-1:0]         if_words_q, filt_words_q, out_words_q;
  logic [CNT_W-1:0]         if_cnt, filt_cnt, out_cnt;
  logic                     if_reached, filt_reached, out_reached;
  logic                     just_add_q, just_add_d, err_q, err_d;
  logic [WD_W-1:0]          wd_q, wd_d;
  logic [FILT_ADDR_LEN-1:0] filt_len_q;
  logic [IF_ADDR_LEN-1:0]   stride_q;
  logic [1:0]               mode_q;

  logic in_stream, is_last, cfg_accept, cnt_clr, any_hs, all_fin;
  logic if_fin, filt_fin, out_fin;

  assign in_stream  = (state_q == ST_STREAM);
  assign is_last    = (pass_cnt_q == last_idx_q);
  assign cfg_ready  = (state_q == ST_IDLE);
  assign cfg_accept = cfg_ready & cfg_valid;
  assign cnt_clr    = (state_q == ST_PASS_END) | (state_q == ST_DONE);

  assign if_s_ready   = in_stream & ~if_reached & ~IF_full;
  assign IF_wen       = if_s_valid & if_s_ready;
  assign IF_din       = if_s_data;
  assign filt_s_ready = in_stream & ~filt_reached & ~filter_full;
  assign filter_wen   = filt_s_valid & filt_s_ready;
  assign filter_din   = filt_s_data;

  // The last pass drains to the result stream, earlier passes recirculate.
  assign outbuf_ren     = in_stream & ~outbuf_empty & ~out_reached &
                          (is_last ? res_ready : ~psum_full);
  assign res_valid      = outbuf_ren & is_last;
  assign res_data       = outbuf_dout;
  assign psum_buf_wen   = outbuf_ren & ~is_last;
  assign P_sum_buff_inp = outbuf_dout;

  // Look ahead by one handshake so PASS_END follows the final word directly.
  assign if_fin   = if_reached   | (IF_wen     & (if_cnt   == if_words_q   - CNT_W'(1)));
  assign filt_fin = filt_reached | (filter_wen & (filt_cnt == filt_words_q - CNT_W'(1)));
  assign out_fin  = out_reached  | (outbuf_ren & (out_cnt  == out_words_q  - CNT_W'(1)));
  assign all_fin  = if_fin & filt_fin & out_fin;
  assign any_hs   = IF_wen | filter_wen | outbuf_ren;

  bounded_counter #(.W(CNT_W)) u_if_cnt (
    .clk(clk), .rst_n(rst_n), .target(if_words_q), .inc(IF_wen),
    .clr(cnt_clr), .count(if_cnt), .reached(if_reached)
  );

  bounded_counter #(.W(CNT_W)) u_filt_cnt (
    .clk(clk), .rst_n(rst_n), .target(filt_words_q), .inc(filter_wen),
    .clr(cnt_clr), .count(filt_cnt), .reached(filt_reached)
  );

  bounded_counter #(.W(CNT_W)) u_out_cnt (
    .clk(clk), .rst_n(rst_n), .target(out_words_q), .inc(outbuf_ren),
    .clr(cnt_clr), .count(out_cnt), .reached(out_reached)
  );

  always_comb begin
    state_d    = state_q;
    pass_cnt_d = pass_cnt_q;
    just_add_d = just_add_q;
    err_d      = err_q;
    wd_d       = '0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_valid) begin
          state_d    = ST_START;
          pass_cnt_d = '0;
          just_add_d = 1'b0;
          err_d      = 1'b0;
        end
      end
      ST_START: state_d = ST_STREAM;
      ST_STREAM: begin
        wd_d = any_hs ? '0 : wd_q + WD_W'(1);
        if (all_fin) begin
          state_d = ST_PASS_END;
        end else if (!any_hs && (wd_q == WD_W'(TIMEOUT - 1))) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_PASS_END: begin
        if (is_last) begin
          state_d = ST_DONE;
        end else begin
          pass_cnt_d = pass_cnt_q + PASS_W'(1);
          just_add_d = 1'b1;
          state_d    = ST_START;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pass_cnt_q <= '0;
      just_add_q <= 1'b0;
      err_q      <= 1'b0;
      wd_q       <= '0;
    end else begin
      state_q    <= state_d;
      pass_cnt_q <= pass_cnt_d;
      just_add_q <= just_add_d;
      err_q      <= err_d;
      wd_q       <= wd_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_len_q   <= '0;
      stride_q     <= '0;
      mode_q       <= '0;
      last_idx_q   <= '0;
      if_words_q   <= '0;
      filt_words_q <= '0;
      out_words_q  <= '0;
    end else if (cfg_accept) begin
      filt_len_q   <= cfg_filt_len;
      stride_q     <= cfg_stride_len;
      mode_q       <= cfg_mode;
      last_idx_q   <= (cfg_passes == '0) ? '0 : cfg_passes - PASS_W'(1);
      if_words_q   <= cfg_if_words;
      filt_words_q <= cfg_filt_words;
      out_words_q  <= cfg_out_words;
    end
  end

  assign start         = (state_q == ST_START);
  assign done          = (state_q == ST_DONE);
  assign busy          = ~cfg_ready;
  assign err           = err_q;
  assign just_add_flag = just_add_q;
  assign filt_len      = filt_len_q;
  assign stride_len    = stride_q;
  assign calc_mod      = mode_q;

endmodule

`default_nettype wire

// File: tb/tb_conv_pass_sequencer.sv
// ============================================================================
// tb_conv_pass_sequencer : directed + randomized jobs against a queue-level model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_conv_pass_sequencer;
  import conv_seq_pkg::*;

  localparam int TO = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_valid, cfg_ready;
  logic [3:0]  cfg_filt_len, cfg_stride_len, cfg_passes;
  logic [1:0]  cfg_mode;
  logic [7:0]  cfg_if_words, cfg_filt_words, cfg_out_words;
  logic        if_s_valid, if_s_ready, filt_s_valid, filt_s_ready;
  logic [17:0] if_s_data, IF_din;
  logic [15:0] filt_s_data, filter_din;
  logic        res_valid, res_ready;
  logic [31:0] res_data, P_sum_buff_inp, outbuf_dout;
  logic        start, IF_wen, filter_wen, outbuf_ren, psum_buf_wen, just_add_flag;
  logic [3:0]  filt_len, stride_len;
  logic [1:0]  calc_mod;
  logic        IF_full, filter_full, outbuf_empty, psum_full;
  logic        busy, done, err;

  always #5 clk = ~clk;

  conv_pass_sequencer #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_filt_len(cfg_filt_len), .cfg_stride_len(cfg_stride_len), .cfg_mode(cfg_mode),
    .cfg_passes(cfg_passes), .cfg_if_words(cfg_if_words),
    .cfg_filt_words(cfg_filt_words), .cfg_out_words(cfg_out_words),
    .if_s_valid(if_s_valid), .if_s_ready(if_s_ready), .if_s_data(if_s_data),
    .filt_s_valid(filt_s_valid), .filt_s_ready(filt_s_ready), .filt_s_data(filt_s_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .start(start), .IF_wen(IF_wen), .filter_wen(filter_wen), .outbuf_ren(outbuf_ren),
    .psum_buf_wen(psum_buf_wen), .just_add_flag(just_add_flag),
    .IF_din(IF_din), .filter_din(filter_din), .P_sum_buff_inp(P_sum_buff_inp),
    .filt_len(filt_len), .stride_len(stride_len), .calc_mod(calc_mod),
    .IF_full(IF_full), .filter_full(filter_full), .outbuf_empty(outbuf_empty),
    .psum_full(psum_full), .outbuf_dout(outbuf_dout),
    .busy(busy), .done(done), .err(err)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [31:0] if_src[$], if_exp[$], if_got[$];
  logic [31:0] f_src[$], f_exp[$], f_got[$];
  logic [31:0] out_q[$], psum_exp[$], psum_got[$], res_exp[$], res_got[$];

  int n_start, ja_mask, start_cyc, done_cyc, last_hs_cyc, acc_cyc, viol;
  int if_full_at, if_full_left, res_block_left, cur_passes, cur_ow;
  bit accepted, done_seen, pending_ja, cur_fixed, cur_resblk, err_at_start, err_at_done;
  logic [9:0] cfg_snap;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit qeq(input logic [31:0] a[$], input logic [31:0] b[$]);
    if (a.size() != b.size()) return 1'b0;
    foreach (a[i]) if (a[i] !== b[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Observe mid-cycle (negedge), then drive the next cycle's inputs at posedge+1.
  task automatic tick();
    logic [31:0] v;
    @(negedge clk);
    cyc++;
    if (if_s_valid && if_s_ready && if_src.size() > 0) begin
      void'(if_src.pop_front());
      last_hs_cyc = cyc;
    end
    if (IF_wen) if_got.push_back(32'(IF_din));
    if (filt_s_valid && filt_s_ready && f_src.size() > 0) begin
      void'(f_src.pop_front());
      last_hs_cyc = cyc;
    end
    if (filter_wen) f_got.push_back(32'(filter_din));
    if (outbuf_ren) begin
      if (out_q.size() > 0) void'(out_q.pop_front());
      last_hs_cyc = cyc;
    end
    if (psum_buf_wen) psum_got.push_back(P_sum_buff_inp);
    if (res_valid && res_ready) res_got.push_back(res_data);
    if (if_full_left > 0) begin
      if (IF_wen || if_s_ready) viol++;
      if_full_left--;
    end
    if (res_block_left > 0) begin
      if (outbuf_ren || res_valid) viol++;
      res_block_left--;
    end
    if (accepted && !done_seen && cyc > acc_cyc && (!busy || cfg_ready)) viol++;
    if (pending_ja) begin
      ja_mask = ja_mask | (int'(just_add_flag) << (n_start - 1));
      pending_ja = 1'b0;
    end
    if (start) begin
      n_start++;
      start_cyc = cyc;
      pending_ja = 1'b1;
      if (n_start == 1) err_at_start = err;
      for (int k = 0; k < cur_ow; k++) begin
        v = cur_fixed ? 32'(k + 1) : $urandom;
        out_q.push_back(v);
        if (n_start < cur_passes) psum_exp.push_back(v);
        else res_exp.push_back(v);
      end
      if (cur_resblk && n_start == cur_passes) res_block_left = 10;
    end
    if (done) begin
      done_seen = 1'b1;
      done_cyc = cyc;
      err_at_done = err;
      cfg_snap = {filt_len, stride_len, calc_mod};
    end
    if (cfg_valid && cfg_ready) begin
      accepted = 1'b1;
      acc_cyc = cyc;
    end
    @(posedge clk);
    #1;
    if (if_full_at == cyc) if_full_left = 5;
    IF_full      = (if_full_left > 0) || ($urandom_range(0, 9) == 0);
    filter_full  = ($urandom_range(0, 9) == 0);
    psum_full    = ($urandom_range(0, 7) == 0);
    res_ready    = (res_block_left == 0) && ($urandom_range(0, 4) != 0);
    if_s_valid   = (if_src.size() > 0) && ($urandom_range(0, 3) != 0);
    if_s_data    = (if_src.size() > 0) ? if_src[0][17:0] : 18'($urandom);
    filt_s_valid = (f_src.size() > 0) && ($urandom_range(0, 3) != 0);
    filt_s_data  = (f_src.size() > 0) ? f_src[0][15:0] : 16'($urandom);
    outbuf_empty = (out_q.size() == 0);
    outbuf_dout  = (out_q.size() > 0) ? out_q[0] : 32'hDEAD_BEEF;
  endtask

  task automatic run_job(input int passes, input int ifw, input int fw, input int ow,
                         input int fl, input int st, input int md,
                         input bit fixed, input bit nosrc, input int if_full_off,
                         input bit resblk, input int rst_off, input bit exp_err);
    int eff, n;
    logic [31:0] v;
    eff = (passes == 0) ? 1 : passes;
    if_src.delete(); if_exp.delete(); if_got.delete();
    f_src.delete(); f_exp.delete(); f_got.delete();
    out_q.delete(); psum_exp.delete(); psum_got.delete(); res_exp.delete(); res_got.delete();
    n_start = 0; ja_mask = 0; viol = 0; pending_ja = 0;
    accepted = 0; done_seen = 0; done_cyc = 0; last_hs_cyc = 0; start_cyc = 0;
    if_full_at = -1; if_full_left = 0; res_block_left = 0;
    cur_passes = eff; cur_ow = ow; cur_fixed = fixed; cur_resblk = resblk;
    if (!nosrc) begin
      for (int k = 0; k < eff * ifw; k++) begin
        v = 32'($urandom_range(0, 262143));
        if_src.push_back(v); if_exp.push_back(v);
      end
      for (int k = 0; k < eff * fw; k++) begin
        v = 32'($urandom_range(0, 65535));
        f_src.push_back(v); f_exp.push_back(v);
      end
    end
    cfg_filt_len = 4'(fl); cfg_stride_len = 4'(st); cfg_mode = 2'(md);
    cfg_passes = 4'(passes); cfg_if_words = 8'(ifw);
    cfg_filt_words = 8'(fw); cfg_out_words = 8'(ow);
    cfg_valid = 1'b1;
    n = 0;
    while (!accepted && n < 50) begin tick(); n++; end
    cfg_valid = 1'b0;
    chk("cfg_accept", accepted, 1);
    if (if_full_off > 0) if_full_at = acc_cyc + if_full_off;
    n = 0;
    while (!done_seen && n < 4000) begin
      if (rst_off > 0 && cyc - acc_cyc == rst_off) begin
        chk("pre_rst_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ctrl", {busy, start, done, err, just_add_flag, if_s_ready, filt_s_ready,
                         IF_wen, filter_wen, outbuf_ren, res_valid, psum_buf_wen, cfg_ready},
            13'b1);
        chk("rst_cfg", {filt_len, stride_len, calc_mod}, 0);
        #4 rst_n = 1'b1;
        tick();
        chk("post_rst_ready", {cfg_ready, busy}, 2'b10);
        return;
      end
      tick();
      n++;
    end
    chk("job_done", done_seen, 1);
    chk("starts", n_start, eff);
    chk("just_add", ja_mask, ((1 << eff) - 1) & ~1);
    chk("if_data", qeq(if_got, if_exp), 1);
    chk("filt_data", qeq(f_got, f_exp), 1);
    chk("psum_data", qeq(psum_got, psum_exp), 1);
    chk("res_data", qeq(res_got, res_exp), 1);
    chk("protocol", viol, 0);
    chk("err_clear_on_accept", err_at_start, 0);
    chk("err_at_done", err_at_done, exp_err);
    chk("cfg_latched", cfg_snap, {4'(fl), 4'(st), 2'(md)});
    if (exp_err) begin
      chk("wdog_lat", ((done_cyc - start_cyc) >= TO + 1) && ((done_cyc - start_cyc) <= TO + 2), 1);
    end else if ((ifw | fw | ow) != 0) begin
      chk("done_lat", done_cyc - last_hs_cyc, 2);
    end
    tick();
    chk("idle_after_done", {cfg_ready, busy, err}, {2'b10, exp_err});
  endtask

  initial begin
    cfg_valid = 0; cfg_filt_len = 0; cfg_stride_len = 0; cfg_mode = 0; cfg_passes = 0;
    cfg_if_words = 0; cfg_filt_words = 0; cfg_out_words = 0;
    if_s_valid = 0; if_s_data = 0; filt_s_valid = 0; filt_s_data = 0; res_ready = 0;
    IF_full = 0; filter_full = 0; outbuf_empty = 1; psum_full = 0; outbuf_dout = 0;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_ctrl", {busy, start, done, err, just_add_flag, if_s_ready, filt_s_ready,
                       IF_wen, filter_wen, outbuf_ren, res_valid, psum_buf_wen, cfg_ready},
        13'b1);
    chk("reset_cfg", {filt_len, stride_len, calc_mod}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single pass, two passes with fixed engine values, IF backpressure, result stall
    run_job(1, 12, 12, 3, 4, 2, 1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
    run_job(2, 4, 4, 2, 3, 1, 2, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
    chk("pass0_psum", {psum_got.size() == 2 ? psum_got[0] : 32'hX, psum_got.size() == 2 ? psum_got[1] : 32'hX},
        {32'd1, 32'd2});
    run_job(1, 12, 12, 3, 5, 3, 0, 1'b0, 1'b0, 4, 1'b0, 0, 1'b0);
    run_job(2, 6, 6, 4, 2, 2, 3, 1'b0, 1'b0, 0, 1'b1, 0, 1'b0);

    // watchdog abort, then a clean job clears err
    run_job(1, 4, 0, 0, 1, 1, 1, 1'b0, 1'b1, 0, 1'b0, 0, 1'b1);
    run_job(1, 3, 3, 2, 6, 1, 0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);

    // asynchronous reset mid-stream
    run_job(1, 12, 12, 3, 4, 2, 1, 1'b0, 1'b0, 0, 1'b0, 6, 1'b0);

    for (int j = 0; j < 6; j++) begin
      run_job($urandom_range(0, 3), $urandom_range(0, 10), $urandom_range(0, 10),
              $urandom_range(0, 10), $urandom_range(0, 15), $urandom_range(0, 15),
              $urandom_range(0, 3), 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
